// File: rtl/data_memory_ctrl.sv
// Single-port data memory for the load/store path: valid/ready requests, byte
// enables, registered one-cycle response and a one-word-per-cycle zero-fill sequencer.
module data_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    input  logic                clear_start,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               in_range;
    logic [IDX_W-1:0]   idx;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign accept    = req_valid && req_ready;
    // Range check on the full address width so high addresses never alias.
    assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
    assign idx       = req_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Array has no reset; contents are only ever cleared by the fill sequencer.
    always_ff @(posedge clk) begin
        if (reset && state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (accept && req_write && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (req_be[k]) begin
                    mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (!req_write && in_range) ? mem[idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl: fill timing, byte enables,
// range errors, back-to-back traffic, clear requests and reset during fill.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clear_start;
    logic        busy;

    int num_checks = 0;
    int num_errors = 0;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .clear_start (clear_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        clear_start = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        num_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b rdata=%h err=%b, expected 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        num_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL reset_busy: got busy=%b ready=%b, expected 1/0", busy, req_ready);
        end
        reset = 1'b1;
        drive(1'b0, 32'd1, 32'h0, 4'h0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            num_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                num_errors++;
                $display("[TB] FAIL fill_blocked: cycle %0d got ready=%b valid=%b, expected 0/0", cnt, req_ready, rsp_valid);
            end
            cnt++;
            @(negedge clk);
        end
        idle();
        num_checks++;
        if (cnt !== 64 || req_ready !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL fill_length: got %0d cycles ready=%b, expected 64 cycles ready=1", cnt, req_ready);
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, i, 32'h0, 4'h0);
            @(negedge clk);
            num_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                num_errors++;
                $display("[TB] FAIL read_zero[%0d]: got valid=%b rdata=%h err=%b, expected 1/0/0", i, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL write_ack: got valid=%b rdata=%h err=%b, expected 1/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        drive(1'b1, 32'd5, 32'h00000011, 4'h1);
        @(negedge clk);
        drive(1'b0, 32'd5, 32'h0, 4'h0);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBE11 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL byte_merge: got valid=%b rdata=%h err=%b, expected 1/deadbe11/0", rsp_valid, rsp_rdata, rsp_err);
        end
        drive(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL noop_write_ack: got valid=%b err=%b, expected 1/0", rsp_valid, rsp_err);
        end
        drive(1'b0, 32'd5, 32'h0, 4'h0);
        @(negedge clk);
        num_checks++;
        if (rsp_rdata !== 32'hDEADBE11) begin
            num_errors++;
            $display("[TB] FAIL noop_write_data: got %h, expected deadbe11", rsp_rdata);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 32'd64, 32'h0, 4'h0);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL err_read_64: got valid=%b rdata=%h err=%b, expected 1/0/1", rsp_valid, rsp_rdata, rsp_err);
        end
        drive(1'b1, 32'h80000005, 32'h55555555, 4'hF);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL err_write_high: got valid=%b err=%b, expected 1/1", rsp_valid, rsp_err);
        end
        drive(1'b0, 32'h80000005, 32'h0, 4'h0);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL err_read_high: got valid=%b rdata=%h err=%b, expected 1/0/1", rsp_valid, rsp_rdata, rsp_err);
        end
        drive(1'b1, 32'd64, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL err_write_64: got valid=%b rdata=%h err=%b, expected 1/0/1", rsp_valid, rsp_rdata, rsp_err);
        end
        idle();
        @(negedge clk);
        num_checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            num_errors++;
            $display("[TB] FAIL hold_outputs: got valid=%b err=%b rdata=%h, expected 0/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        drive(1'b0, 32'd0, 32'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 32'd5, 32'h0, 4'h0);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL no_alias_0: got valid=%b rdata=%h err=%b, expected 1/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        num_checks++;
        if (rsp_rdata !== 32'hDEADBE11 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL no_alias_5: got rdata=%h err=%b, expected deadbe11/0", rsp_rdata, rsp_err);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h0;
        exp_data[1] = 32'h12345678;
        exp_data[2] = 32'h0;
        drive(1'b1, 32'd7, 32'h12345678, 4'hF);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b0, 32'd7, 32'h0, 4'h0);
            else if (i == 1) drive(1'b0, 32'd8, 32'h0, 4'h0);
            else idle();
            num_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[i] || rsp_err !== 1'b0) begin
                num_errors++;
                $display("[TB] FAIL b2b[%0d]: got valid=%b rdata=%h err=%b, expected 1/%h/0", i, rsp_valid, rsp_rdata, rsp_err, exp_data[i]);
            end
            @(negedge clk);
        end
        num_checks++;
        if (rsp_valid !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL b2b_end: got valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_clear_with_write();
        int cnt;
        drive(1'b1, 32'd3, 32'hAAAAAAAA, 4'hF);
        clear_start = 1'b1;
        @(negedge clk);
        idle();
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL clear_write_ack: got valid=%b rdata=%h err=%b, expected 1/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            clear_start = (cnt == 30);
            cnt++;
            @(negedge clk);
        end
        idle();
        num_checks++;
        if (cnt !== 64 || req_ready !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL clear_length: got %0d cycles ready=%b, expected 64 cycles ready=1", cnt, req_ready);
        end
        drive(1'b0, 32'd3, 32'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 32'd7, 32'h0, 4'h0);
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL cleared_3: got valid=%b rdata=%h err=%b, expected 1/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        idle();
        num_checks++;
        if (rsp_rdata !== 32'h0) begin
            num_errors++;
            $display("[TB] FAIL cleared_7: got %h, expected 0", rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int cnt;
        drive(1'b1, 32'd5, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        drive(1'b0, 32'd5, 32'h0, 4'h0);
        @(negedge clk);
        idle();
        num_checks++;
        if (rsp_rdata !== 32'hCAFEF00D || rsp_valid !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL pre_reset_read: got valid=%b rdata=%h, expected 1/cafef00d", rsp_valid, rsp_rdata);
        end
        #1 reset = 1'b0;
        #1;
        num_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL async_reset_rsp: got valid=%b rdata=%h busy=%b, expected 0/0/1", rsp_valid, rsp_rdata, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        num_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL reset_in_fill: got busy=%b ready=%b valid=%b, expected 1/0/0", busy, req_ready, rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        num_checks++;
        if (cnt !== 64 || req_ready !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL refill_length: got %0d cycles ready=%b, expected 64 cycles ready=1", cnt, req_ready);
        end
        drive(1'b0, 32'd5, 32'h0, 4'h0);
        @(negedge clk);
        idle();
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            num_errors++;
            $display("[TB] FAIL refill_read_5: got valid=%b rdata=%h, expected 1/0", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        $display("[TB] starting directed tests");
        test_reset();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_clear_with_write();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
